// File: rtl/driver_alert_pkg.sv
// Shared state encodings for the driver alert monitor.
package driver_alert_pkg;

    typedef enum logic [2:0] {
        NORMAL  = 3'd0,
        PENDING = 3'd1,
        WARNING = 3'd2,
        ALARM   = 3'd3,
        RECOVER = 3'd4
    } state_e;

endpackage

// File: rtl/driver_alert_monitor_trigger.sv
// Combinational reduction of the sensor channels into a failure vector and a
// single trigger, in either any-channel or all-channel mode.
module alert_trigger #(
    parameter int N_CH     = 3,
    parameter bit TRIG_ALL = 1'b0
) (
    input  logic [N_CH-1:0] sensor_ok,
    input  logic [N_CH-1:0] ch_en,
    output logic [N_CH-1:0] fail_vec,
    output logic            trig
);

    always_comb begin
        fail_vec = ch_en & ~sensor_ok;
        if (TRIG_ALL) begin
            // With nothing enabled there is nothing to fail, so no trigger.
            trig = (ch_en != '0) && (fail_vec == ch_en);
        end else begin
            trig = |fail_vec;
        end
    end

endmodule

// File: rtl/driver_alert_monitor.sv
// Driver-condition alert monitor: debounce, warning, latched alarm and a
// recovery window before returning to normal. Outputs decode registered state.
module driver_alert_monitor
    import driver_alert_pkg::*;
#(
    parameter int N_CH           = 3,
    parameter int CNT_W          = 8,
    parameter int WARN_CYCLES    = 4,
    parameter int ALARM_CYCLES   = 8,
    parameter int RECOVER_CYCLES = 2,
    parameter bit TRIG_ALL       = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sensor_ok,
    input  logic [N_CH-1:0] ch_en,
    input  logic            ack,
    output logic            ok,
    output logic            warn,
    output logic            alarm,
    output logic [N_CH-1:0] fault_ch,
    output logic [2:0]      state_o
);

    if (WARN_CYCLES < 2 || WARN_CYCLES >= (1 << CNT_W) ||
        ALARM_CYCLES < 1 || ALARM_CYCLES >= (1 << CNT_W) ||
        RECOVER_CYCLES < 2 || RECOVER_CYCLES >= (1 << CNT_W)) begin : g_param_err
        $error("driver_alert_monitor: threshold out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] WARN_LAST    = CNT_W'(WARN_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALARM_LAST   = CNT_W'(ALARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(RECOVER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic [N_CH-1:0]  fail_vec;
    logic             trig;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]  fault_q, fault_d;

    alert_trigger #(
        .N_CH     (N_CH),
        .TRIG_ALL (TRIG_ALL)
    ) u_trigger (
        .sensor_ok (sensor_ok),
        .ch_en     (ch_en),
        .fail_vec  (fail_vec),
        .trig      (trig)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        case (state_q)
            NORMAL: begin
                if (trig) begin
                    state_d = PENDING;
                    cnt_d   = CNT_ONE;
                end
            end
            PENDING: begin
                if (!trig) begin
                    state_d = NORMAL;
                    cnt_d   = '0;
                end else if (cnt_q == WARN_LAST) begin
                    state_d = WARNING;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WARNING: begin
                if (!trig) begin
                    state_d = RECOVER;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q == ALARM_LAST) begin
                    state_d = ALARM;
                    cnt_d   = '0;
                    fault_d = fail_vec;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ALARM: begin
                fault_d = fault_q | fail_vec;
                // An acknowledge only counts once the condition has cleared.
                if (ack && !trig) begin
                    state_d = RECOVER;
                    cnt_d   = CNT_ONE;
                end
            end
            RECOVER: begin
                if (trig) begin
                    state_d = WARNING;
                    cnt_d   = '0;
                end else if (cnt_q == RECOVER_LAST) begin
                    state_d = NORMAL;
                    cnt_d   = '0;
                    fault_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = NORMAL;
                cnt_d   = '0;
                fault_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
            fault_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign ok       = (state_q == NORMAL);
    assign warn     = (state_q == WARNING);
    assign alarm    = (state_q == ALARM);
    assign fault_ch = fault_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_driver_alert_monitor.sv
// Directed bench for driver_alert_monitor: one any-channel and one
// all-channel instance share stimulus; expectations are hand-derived.
module tb_driver_alert_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] sensor_ok;
    logic [2:0] ch_en;
    logic       ack;

    logic       ok_a, warn_a, alarm_a;
    logic [2:0] fault_a, state_a;
    logic       ok_b, warn_b, alarm_b;
    logic [2:0] fault_b, state_b;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    driver_alert_monitor #(
        .N_CH(3), .CNT_W(8), .WARN_CYCLES(4), .ALARM_CYCLES(8),
        .RECOVER_CYCLES(2), .TRIG_ALL(1'b0)
    ) dut_any (
        .clk(clk), .reset(reset), .sensor_ok(sensor_ok), .ch_en(ch_en), .ack(ack),
        .ok(ok_a), .warn(warn_a), .alarm(alarm_a), .fault_ch(fault_a), .state_o(state_a)
    );

    driver_alert_monitor #(
        .N_CH(3), .CNT_W(8), .WARN_CYCLES(4), .ALARM_CYCLES(8),
        .RECOVER_CYCLES(2), .TRIG_ALL(1'b1)
    ) dut_all (
        .clk(clk), .reset(reset), .sensor_ok(sensor_ok), .ch_en(ch_en), .ack(ack),
        .ok(ok_b), .warn(warn_b), .alarm(alarm_b), .fault_ch(fault_b), .state_o(state_b)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; sensor_ok = 3'b111; ch_en = 3'b111; ack = 1'b0;
        tick(2);
        chk("rst_ok",    int'(ok_a), 1);
        chk("rst_warn",  int'(warn_a), 0);
        chk("rst_alarm", int'(alarm_a), 0);
        chk("rst_fault", int'(fault_a), 0);
        chk("rst_state", int'(state_a), 0);
        chk("rst_state_all", int'(state_b), 0);

        // Short glitch on channel 0 is filtered.
        reset = 1'b0; sensor_ok = 3'b110;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            chk($sformatf("glitch_state_%0d", k), int'(state_a), 1);
            chk($sformatf("glitch_warn_%0d", k), int'(warn_a), 0);
        end
        sensor_ok = 3'b111;
        tick(1);
        chk("glitch_back", int'(state_a), 0);
        chk("glitch_ok",   int'(ok_a), 1);

        // Channel 1 held failing: warn after edge 4, alarm after edge 12.
        sensor_ok = 3'b101;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            chk($sformatf("esc_state_%0d", k), int'(state_a), (k < 4) ? 1 : (k < 12) ? 2 : 3);
        end
        chk("esc_warn_off", int'(warn_a), 0);
        chk("esc_alarm",    int'(alarm_a), 1);
        chk("esc_fault",    int'(fault_a), 3'b010);
        chk("esc_all_quiet", int'(state_b), 0);

        // Ack while still failing is ignored.
        ack = 1'b1;
        tick(1);
        chk("ack_ignored", int'(state_a), 3);
        sensor_ok = 3'b111;
        tick(1);
        chk("ack_recover", int'(state_a), 4);
        chk("ack_fault_kept", int'(fault_a), 3'b010);
        ack = 1'b0;
        tick(1);
        chk("rec_normal", int'(state_a), 0);
        chk("rec_ok",     int'(ok_a), 1);
        chk("rec_fault",  int'(fault_a), 0);

        // All-channel mode: a partial failure does not trigger.
        sensor_ok = 3'b010;
        tick(5);
        chk("all_partial", int'(state_b), 0);
        sensor_ok = 3'b000;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            chk($sformatf("all_state_%0d", k), int'(state_b), (k < 4) ? 1 : (k < 12) ? 2 : 3);
        end
        chk("all_alarm", int'(alarm_b), 1);
        chk("all_fault", int'(fault_b), 3'b111);

        // No enabled channels: neither mode triggers.
        reset = 1'b1;
        tick(1);
        reset = 1'b0; ch_en = 3'b000;
        tick(3);
        chk("noen_any", int'(state_a), 0);
        chk("noen_all", int'(state_b), 0);

        // Reset mid-alarm with trigger held, then resume into PENDING.
        ch_en = 3'b111; sensor_ok = 3'b101;
        tick(12);
        chk("pre_rst_alarm", int'(alarm_a), 1);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_state", int'(state_a), 0);
        chk("mid_rst_ok",    int'(ok_a), 1);
        chk("mid_rst_fault", int'(fault_a), 0);
        reset = 1'b0;
        tick(1);
        chk("post_rst_pending", int'(state_a), 1);

        // WARNING -> RECOVER on one clean edge, straight back to WARNING on trig.
        tick(3);
        chk("rw_warn", int'(state_a), 2);
        sensor_ok = 3'b111;
        tick(1);
        chk("rw_recover", int'(state_a), 4);
        sensor_ok = 3'b101;
        tick(1);
        chk("rw_rewarn", int'(state_a), 2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/driver_alert_monitor.md
Name: driver_alert_monitor

Overview:
- Parametrised successor to the single-FSM driver-safety interlock (steering / seatbelt / eye sensors).
- Monitors N_CH driver-condition sensor channels, each individually enabled.
- Escalates through debounce, warning and latched alarm; alarm clears only after an operator acknowledge and a clean recovery window.
- Sits between the raw sensor switches and the dashboard LED / buzzer drivers in the vehicle-safety subsystem.

Parameters:
- N_CH, 3: number of sensor channels.
- CNT_W, 8: width of the internal dwell counter.
- WARN_CYCLES, 4: consecutive trigger edges before warn; must be >=2.
- ALARM_CYCLES, 8: consecutive trigger edges spent in WARNING before alarm; must be >=1.
- RECOVER_CYCLES, 2: consecutive clean edges before returning to NORMAL; must be >=2.
- TRIG_ALL, 0: 0 = any enabled channel failing triggers; 1 = all enabled channels must fail (legacy interlock semantics).

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high; dominates every other input.
- sensor_ok  in  N_CH  1 = channel condition satisfied.
- ch_en  in  N_CH  1 = channel participates.
- ack  in  1  operator alarm acknowledge, level-sampled.
- ok  out  1  1 only in NORMAL.
- warn  out  1  1 only in WARNING.
- alarm  out  1  1 only in ALARM.
- fault_ch  out  N_CH  sticky record of channels failing while in ALARM.
- state_o  out  3  current state encoding.

Behaviour:
- fail_vec = ch_en & ~sensor_ok, sampled every posedge.
- trig = TRIG_ALL ? (ch_en != 0 && fail_vec == ch_en) : |fail_vec.
- ch_en == 0 gives trig = 0. ch_en changes take effect on the same edge.
- Reset values: state NORMAL, cnt 0, ok = 1, warn = 0, alarm = 0, fault_ch = 0.
- Outputs are a pure decode of registered state (Moore). No combinational input-to-output path.
- NORMAL:
  - trig -> PENDING, cnt <= 1.
- PENDING:
  - !trig -> NORMAL, cnt <= 0 (glitch filtered).
  - trig and cnt == WARN_CYCLES-1 -> WARNING, cnt <= 0.
  - otherwise cnt++.
  - Net effect: warn rises after the WARN_CYCLES-th consecutive trig edge.
- WARNING:
  - !trig -> RECOVER, cnt <= 1.
  - trig and cnt == ALARM_CYCLES-1 -> ALARM, cnt <= 0, fault_ch <= fail_vec.
  - otherwise cnt++.
- ALARM:
  - Latched. fault_ch <= fault_ch | fail_vec every edge.
  - Exit only when ack = 1 and trig = 0 on the same edge -> RECOVER, cnt <= 1.
  - ack while trig = 1 is ignored.
- RECOVER:
  - trig -> WARNING, cnt <= 0 (no re-debounce).
  - !trig and cnt == RECOVER_CYCLES-1 -> NORMAL, cnt <= 0, fault_ch <= 0.
  - otherwise cnt++.
- ack is ignored outside ALARM.
- Counter never wraps; it is always reloaded at thresholds. Thresholds >= 2^CNT_W or below their stated minimum are an elaboration-time error.
- Reset in any state, including mid-ALARM with trig held: next edge gives reset values.
- After reset deasserts with trig still high: PENDING on the following edge.

Decomposition:
- Shared package driver_alert_pkg holds the state encodings: NORMAL = 3'd0, PENDING = 3'd1, WARNING = 3'd2, ALARM = 3'd3, RECOVER = 3'd4. The remaining codes are illegal and recover to NORMAL.
- One natural sub-module, alert_trigger: combinational reduction producing fail_vec and trig, parametrised by N_CH and TRIG_ALL.
- FSM, counter and fault_ch stay in driver_alert_monitor.

Test Plan:
All scenarios use N_CH=3, WARN=4, ALARM=8, RECOVER=2.
1. Reset pulse -> ok=1, warn=0, alarm=0, fault_ch=000, state_o=0.
2. TRIG_ALL=0, ch_en=111, sensor_ok=110 for 3 edges then 111 -> state_o 1 then 0; warn never asserts.
3. sensor_ok=101 held -> warn=1 after edge 4; alarm=1 after edge 12; fault_ch=010.
4. In ALARM, ack=1 with sensor_ok=101 -> stays ALARM. Then sensor_ok=111 plus a one-edge ack -> RECOVER; NORMAL 2 edges later with ok=1, fault_ch=000.
5. TRIG_ALL=1, ch_en=111:
   - sensor_ok=010 -> no trigger.
   - sensor_ok=000 -> escalates as in scenario 3.
   - ch_en=000 with sensor_ok=000 -> stays NORMAL.
6. reset=1 while in ALARM with trig held -> next edge gives reset values. Deassert reset with trig still held -> PENDING next edge.
